ad9643_spi_cfg: RTL and testbench
=================================

Name: ad9643_spi_cfg

Overview:
SPI configuration master for the AD9643 ADC's 3-wire port (sclk, csb, sdio).
- After `start`, it walks a parameterised init table of register writes.
- It also serves single read/write requests from a host port.
- It is the only driver of the ADC SPI pins and sits beside the ADC DDR capture path in the DSP testbench/FPGA top.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles (>=2)
N_INIT, 4, number of init table entries (>=1)
INIT_TABLE, {N_INIT{21'h0}}, packed entries {addr[12:0],data[7:0]}; entry 0 in LSBs
CSB_GAP, 2, clk cycles csb held high between frames (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse: run init table
req_valid  in  1  host request valid
req_ready  out  1  host request accepted this cycle when valid&ready
req_rw  in  1  1=read, 0=write
req_addr  in  13  register address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse: host transaction finished
rsp_rdata  out  8  read data (valid with rsp_valid; 0 for writes)
busy  out  1  any frame or sequence in progress
init_done  out  1  sticky: init table completed
err  out  1  sticky: readback mismatch (feature only)
sclk  out  1  SPI clock, idles low
csb  out  1  chip select, active-low
sdio_o  out  1  serial data out
sdio_oe  out  1  sdio output enable
sdio_i  in  1  serial data in

Behaviour:
- Reset values: sclk=0, csb=1, sdio_o=0, sdio_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, init_done=0, err=0, FSM=IDLE.
- Reset mid-frame aborts the frame; the pins return to their reset values on the clock edge where rst is sampled high.
- Frame format: 24 bits, MSB first.
  - Instruction is {rw, 2'b00 (W1:W0 = 1 byte), addr[12:0]}, followed by data[7:0].
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE/next.
- IDLE:
  - init_pend is set by `start`.
  - If init_pend, load entry idx as a write; init has priority over the host.
  - Otherwise req_ready=1. On valid&ready, latch rw/addr/wdata, then go to CS_SETUP.
  - `start` while busy sets init_pend; the table runs after the current frame. Repeated pulses collapse into one run.
- CS_SETUP (CLK_DIV cycles): csb=0, sdio_oe=1, sdio_o=bit23.
- SHIFT:
  - sclk toggles every CLK_DIV cycles, starting high.
  - sdio_o advances to the next bit on each falling sclk edge.
  - Exactly 24 rising edges; the state ends after the 24th low half-period.
- Reads:
  - sdio_oe drops on the falling edge after rising edge 16.
  - sdio_i is sampled in the clk cycle where sclk goes 0->1 for edges 17..24 and shifted into rdata, MSB first.
- CS_HOLD: CLK_DIV cycles with sclk=0, then csb=1, sdio_oe=0.
- GAP: CSB_GAP cycles with csb=1.
- Sequencing after GAP:
  - Init: idx increments. When idx==N_INIT-1 completes, set init_done, clear init_pend, reset idx=0.
  - Host: rsp_valid pulses for one cycle in the final GAP cycle.
- busy=1 in every state except IDLE with no init_pend.
- A host frame in flight when `start` arrives completes and reports rsp_valid before the init table begins.
- Frame duration: (2 + 48 + CSB_GAP/CLK_DIV) scaled; exactly CLK_DIV*(1+48+1)+CSB_GAP clk cycles from leaving IDLE to returning to IDLE.

Optional Feature:
AD9643_CFG_READBACK_EN
- Defined:
  - Each init write is followed by a read of the same address, using the same frame timing.
  - A mismatch sets err (sticky until rst), but the sequence continues.
  - init_done is set after the final verify read.
- Undefined: no verify frames; err is tied to 0 and sdio_i is used only for host reads.

Test Plan:
- Reset check: rst held 3 cycles during a mid-frame SHIFT -> the cycle after, csb=1, sclk=0, sdio_oe=0, busy=0, FSM=IDLE.
- Init run: INIT_TABLE={addr 0x014,data 0x01; addr 0x016,data 0x20}, N_INIT=2, start pulse.
  - Expect two 24-bit frames decoding to 0x001401 and 0x001620.
  - Expect init_done=1 and rsp_valid never pulsed.
- Host write: addr 0x0FF, wdata 0x01, CLK_DIV=4, CSB_GAP=2.
  - Frame bits 0x00FF01 sampled on rising sclk.
  - rsp_valid exactly 4*50+2=202 cycles after acceptance.
- Host read: addr 0x001, SPI slave model drives 0x82 on edges 17..24.
  - Instruction 0x8001; sdio_oe low from after edge 16.
  - rsp_rdata=0x82.
- Priority: req_valid held high and start pulsed in the same cycle while IDLE -> init frames run first, req_ready=0 throughout, host frame issued afterwards.
- With AD9643_CFG_READBACK_EN: slave returns 0x00 for a table write of 0x01 -> write/read frame pair issued, err=1, init_done=1 at the end.

Source files
------------

// File: rtl/ad9643_spi_cfg.sv
// ad9643_spi_cfg: 3-wire SPI configuration master for the AD9643 (init table walk + host read/write port).
// Optional init readback verify is enabled by defining AD9643_CFG_READBACK_EN.
module ad9643_spi_cfg #(
  parameter int unsigned          CLK_DIV    = 4,
  parameter int unsigned          N_INIT     = 4,
  parameter logic [N_INIT*21-1:0] INIT_TABLE = '0,
  parameter int unsigned          CSB_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        init_done,
  output logic        err,
  output logic        sclk,
  output logic        csb,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        sdio_i
);
  localparam int unsigned CW = 16;
  localparam int unsigned IW = (N_INIT > 1) ? $clog2(N_INIT) : 1;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    half_q, half_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          frame_rw_q, frame_rw_d;
  logic          frame_init_q, frame_init_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          init_pend_q, init_pend_d;
  logic          init_done_q, init_done_d;
  logic          sclk_q, sclk_d, csb_q, csb_d;
  logic          sdio_o_q, sdio_o_d, sdio_oe_q, sdio_oe_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          busy_q, busy_d;
`ifdef AD9643_CFG_READBACK_EN
  logic          verify_q, verify_d;
  logic          err_q, err_d;
`endif

  logic [20:0] table_arr [N_INIT];
  logic [20:0] entry;
  logic        div_last, load, advance, pend_clr, host_ready;

  always_comb begin
    for (int unsigned i = 0; i < N_INIT; i++) table_arr[i] = INIT_TABLE[i*21 +: 21];
  end

  assign entry    = table_arr[idx_q];
  assign div_last = (cnt_q == CW'(CLK_DIV - 1));
  // Ready drops in the start cycle itself so init always wins over a simultaneous host request.
  assign host_ready = req_ready_q & ~start;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    shreg_d      = shreg_q;
    rdata_d      = rdata_q;
    frame_rw_d   = frame_rw_q;
    frame_init_d = frame_init_q;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    sclk_d       = sclk_q;
    csb_d        = csb_q;
    sdio_o_d     = sdio_o_q;
    sdio_oe_d    = sdio_oe_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    load         = 1'b0;
    advance      = 1'b0;
    pend_clr     = 1'b0;
`ifdef AD9643_CFG_READBACK_EN
    verify_d     = verify_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (init_pend_q) begin
          load         = 1'b1;
          frame_init_d = 1'b1;
`ifdef AD9643_CFG_READBACK_EN
          frame_rw_d   = verify_q;
`else
          frame_rw_d   = 1'b0;
`endif
          shreg_d = {frame_rw_d, 2'b00, entry[20:8], frame_rw_d ? 8'h00 : entry[7:0]};
        end else if (req_valid && host_ready) begin
          load         = 1'b1;
          frame_init_d = 1'b0;
          frame_rw_d   = req_rw;
          shreg_d      = {req_rw, 2'b00, req_addr, req_rw ? 8'h00 : req_wdata};
        end
        if (load) begin
          state_d   = CS_SETUP;
          csb_d     = 1'b0;
          sdio_oe_d = 1'b1;
          sdio_o_d  = shreg_d[23];
          rdata_d   = '0;
        end
      end
      CS_SETUP: begin
        if (div_last) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      SHIFT: begin
        if (div_last) begin
          cnt_d = '0;
          if (half_q == 6'd47) begin
            state_d = CS_HOLD;
            sclk_d  = 1'b0;
          end else begin
            half_d = half_q + 1'b1;
            if (!half_q[0]) begin
              sclk_d   = 1'b0;
              shreg_d  = {shreg_q[22:0], 1'b0};
              sdio_o_d = shreg_q[22];
              // Half-period 30 is the 16th high phase: turn the line around for the data byte.
              if (frame_rw_q && half_q >= 6'd30) begin
                sdio_oe_d = 1'b0;
                sdio_o_d  = 1'b0;
              end
            end else begin
              sclk_d = 1'b1;
              if (frame_rw_q && half_q >= 6'd31) rdata_d = {rdata_q[6:0], sdio_i};
            end
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      CS_HOLD: begin
        if (div_last) begin
          state_d   = GAP;
          cnt_d     = '0;
          csb_d     = 1'b1;
          sdio_oe_d = 1'b0;
          sdio_o_d  = 1'b0;
          if (!frame_init_q && CSB_GAP == 1) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = frame_rw_q ? rdata_q : '0;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      GAP: begin
        if (!frame_init_q && (cnt_q + 1'b1 == CW'(CSB_GAP - 1))) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = frame_rw_q ? rdata_q : '0;
        end
        if (cnt_q == CW'(CSB_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (frame_init_q) begin
`ifdef AD9643_CFG_READBACK_EN
            if (!verify_q) verify_d = 1'b1;
            else begin
              verify_d = 1'b0;
              if (rdata_q != entry[7:0]) err_d = 1'b1;
              advance = 1'b1;
            end
`else
            advance = 1'b1;
`endif
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_q == IW'(N_INIT - 1)) begin
        idx_d       = '0;
        init_done_d = 1'b1;
        pend_clr    = 1'b1;
      end else idx_d = idx_q + 1'b1;
    end
    init_pend_d = (init_pend_q & ~pend_clr) | start;
    req_ready_d = (state_d == IDLE) && !init_pend_d;
    busy_d      = !((state_d == IDLE) && !init_pend_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      half_q       <= '0;
      shreg_q      <= '0;
      rdata_q      <= '0;
      frame_rw_q   <= 1'b0;
      frame_init_q <= 1'b0;
      idx_q        <= '0;
      init_pend_q  <= 1'b0;
      init_done_q  <= 1'b0;
      sclk_q       <= 1'b0;
      csb_q        <= 1'b1;
      sdio_o_q     <= 1'b0;
      sdio_oe_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
`ifdef AD9643_CFG_READBACK_EN
      verify_q     <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      shreg_q      <= shreg_d;
      rdata_q      <= rdata_d;
      frame_rw_q   <= frame_rw_d;
      frame_init_q <= frame_init_d;
      idx_q        <= idx_d;
      init_pend_q  <= init_pend_d;
      init_done_q  <= init_done_d;
      sclk_q       <= sclk_d;
      csb_q        <= csb_d;
      sdio_o_q     <= sdio_o_d;
      sdio_oe_q    <= sdio_oe_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
`ifdef AD9643_CFG_READBACK_EN
      verify_q     <= verify_d;
      err_q        <= err_d;
`endif
    end
  end

  assign req_ready = host_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign sclk      = sclk_q;
  assign csb       = csb_q;
  assign sdio_o    = sdio_o_q;
  assign sdio_oe   = sdio_oe_q;
`ifdef AD9643_CFG_READBACK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ad9643_spi_cfg.sv
// Bench for ad9643_spi_cfg: frame-level pin decoder, SPI slave model and expectation queues.
module tb_ad9643_spi_cfg;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned N_INIT    = 2;
  localparam int unsigned CSB_GAP   = 2;
  localparam int unsigned FRAME_CYC = CLK_DIV * 50 + CSB_GAP;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        req_valid = 1'b0, req_rw = 1'b0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, busy, init_done, err;
  logic [7:0]  rsp_rdata;
  logic        sclk, csb, sdio_o, sdio_oe;
  logic        sdio_i = 1'b0;

  ad9643_spi_cfg #(
    .CLK_DIV   (CLK_DIV),
    .N_INIT    (N_INIT),
    .INIT_TABLE({21'h01620, 21'h01401}),
    .CSB_GAP   (CSB_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .init_done(init_done), .err(err),
    .sclk(sclk), .csb(csb), .sdio_o(sdio_o), .sdio_oe(sdio_oe), .sdio_i(sdio_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] word;
    bit          rd;
    bit          last_init;
  } frame_t;

  int          checks = 0, failures = 0;
  int unsigned cyc = 0;
  frame_t      exp_frames[$];
  logic [7:0]  exp_rsp[$];
  int unsigned acc_cyc = 0;
  bit          init_done_exp = 1'b0;
  int          done_cd = 0;
  int          frames_seen = 0;
  logic [23:0] last_word = '0;
  logic [7:0]  rd_val = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SPI slave: presents rd_val MSB first, changing data on falling sclk after rising edges 16..23.
  int   sl_cnt = 0;
  logic sl_prev = 1'b0;
  always @(negedge clk) begin
    if (csb) sl_cnt = 0;
    else if (sclk && !sl_prev) sl_cnt++;
    else if (!sclk && sl_prev && sl_cnt >= 16 && sl_cnt <= 23) sdio_i = rd_val[23 - sl_cnt];
    sl_prev = sclk;
  end

  // Compare process: pin decoding and per-cycle checks against the expectation queues.
  bit          in_frame = 1'b0, prev_sclk = 1'b0, prev_csb = 1'b1;
  logic [23:0] cap_w, cap_oe;
  int          nbits, low_len;
  frame_t      cf;
  logic [7:0]  cr;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0; prev_sclk = 1'b0; prev_csb = 1'b1;
      init_done_exp = 1'b0; done_cd = 0;
    end else begin
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) init_done_exp = 1'b1;
      end
      chk("init_done", init_done, init_done_exp);
`ifndef AD9643_CFG_READBACK_EN
      chk("err_zero", err, 0);
`endif
      if (csb) chk("idle_pins", {sclk, sdio_oe}, 0);
      if (!busy) chk("busy_csb", csb, 1);
      if (req_valid && req_ready) acc_cyc = cyc;
      if (!csb && prev_csb) begin
        in_frame = 1'b1; nbits = 0; cap_w = '0; cap_oe = '0; low_len = 0;
      end
      if (!csb) low_len++;
      if (in_frame && sclk && !prev_sclk) begin
        cap_w  = {cap_w[22:0], sdio_o};
        cap_oe = {cap_oe[22:0], sdio_oe};
        nbits++;
      end
      if (in_frame && csb && !prev_csb) begin
        in_frame = 1'b0;
        frames_seen++;
        last_word = cap_w;
        chk("frame_edges", nbits, 24);
        chk("frame_csb_low", low_len, CLK_DIV * 50);
        chk("frame_expected", exp_frames.size() > 0, 1);
        if (exp_frames.size() > 0) begin
          cf = exp_frames.pop_front();
          if (cf.rd) begin
            chk("rd_instr", cap_w[23:8], cf.word[23:8]);
            chk("rd_oe", cap_oe, 24'hFFFF00);
          end else begin
            chk("wr_frame", cap_w, cf.word);
            chk("wr_oe", cap_oe, 24'hFFFFFF);
          end
          if (cf.last_init) done_cd = CSB_GAP;
        end
      end
      if (rsp_valid) begin
        chk("rsp_expected", exp_rsp.size() > 0, 1);
        if (exp_rsp.size() > 0) begin
          cr = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, cr);
          chk("rsp_latency", cyc - acc_cyc, FRAME_CYC);
        end
      end
      prev_sclk = sclk;
      prev_csb  = csb;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1);
  endtask

  task automatic push_host(input logic rw, input logic [12:0] a, input logic [7:0] d, input logic [7:0] rv);
    frame_t f;
    f.word = {rw, 2'b00, a, rw ? 8'h00 : d};
    f.rd = rw;
    f.last_init = 1'b0;
    exp_frames.push_back(f);
    exp_rsp.push_back(rw ? rv : 8'h00);
  endtask

  task automatic push_init();
    logic [12:0] ta [2];
    logic [7:0]  td [2];
    frame_t f;
    ta[0] = 13'h014; td[0] = 8'h01;
    ta[1] = 13'h016; td[1] = 8'h20;
    for (int i = 0; i < N_INIT; i++) begin
      f.word = {1'b0, 2'b00, ta[i], td[i]};
      f.rd = 1'b0;
      f.last_init = (i == N_INIT - 1);
`ifdef AD9643_CFG_READBACK_EN
      f.last_init = 1'b0;
      exp_frames.push_back(f);
      f.word = {1'b1, 2'b00, ta[i], 8'h00};
      f.rd = 1'b1;
      f.last_init = (i == N_INIT - 1);
`endif
      exp_frames.push_back(f);
    end
  endtask

  task automatic host_req(input logic rw, input logic [12:0] a, input logic [7:0] d, input logic [7:0] rv);
    push_host(rw, a, d, rv);
    rd_val = rv;
    req_rw = rw; req_addr = a; req_wdata = d; req_valid = 1'b1;
    wait_accept("host_accept_timeout");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int base;

  initial begin
    // Reset values while rst is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", csb, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdio", {sdio_o, sdio_oe}, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst_flags", {busy, init_done, err}, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);

    // Host write 0x0FF <- 0x01
    tick();
    host_req(1'b0, 13'h0FF, 8'h01, 8'h00);
    wait_idle("host_wr_idle");
    chk("host_wr_literal", last_word, 24'h00FF01);
    chk("host_wr_rsp_seen", exp_rsp.size(), 0);

    // Host read 0x001, slave returns 0x82
    tick();
    host_req(1'b1, 13'h001, 8'h00, 8'h82);
    wait_idle("host_rd_idle");
    chk("host_rd_instr_literal", last_word[23:8], 16'h8001);
    chk("host_rd_data_literal", rsp_rdata, 8'h82);
    chk("host_rd_rsp_seen", exp_rsp.size(), 0);

    // Init table run
    rd_val = 8'h00;
    base = frames_seen;
    push_init();
    tick();
    pulse_start();
    wait_idle("init_idle");
    chk("init_done_literal", init_done, 1);
    chk("init_last_literal", last_word[23:8], 16'h0016 | (last_word[23] ? 16'h8000 : 16'h0000));
`ifdef AD9643_CFG_READBACK_EN
    chk("init_frame_count", frames_seen - base, 4);
    chk("readback_err", err, 1);
`else
    chk("init_frame_count", frames_seen - base, 2);
    chk("init_last_word", last_word, 24'h001620);
`endif
    chk("init_frames_seen", exp_frames.size(), 0);

    // Reset in the middle of a SHIFT phase
    tick();
    host_req(1'b0, 13'h155, 8'hAA, 8'h00);
    repeat (60) tick();
    chk("midframe_active", {busy, csb}, 2'b10);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    exp_frames.delete();
    exp_rsp.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_pins", {csb, sclk, sdio_oe}, 3'b100);
    chk("postrst_flags", {busy, init_done, err}, 0);
    tick();
    @(negedge clk);
    chk("postrst_idle_ready", req_ready, 1);

    // Priority: start and req_valid raised together; init must run before the host frame
    rd_val = 8'h00;
    base = frames_seen;
    push_init();
    push_host(1'b0, 13'h123, 8'h5A, 8'h00);
    tick();
    req_rw = 1'b0; req_addr = 13'h123; req_wdata = 8'h5A; req_valid = 1'b1;
    pulse_start();
    wait_accept("prio_accept_timeout");
    chk("prio_init_first", init_done, 1);
`ifdef AD9643_CFG_READBACK_EN
    chk("prio_frames_before_host", frames_seen - base, 4);
`else
    chk("prio_frames_before_host", frames_seen - base, 2);
`endif
    wait_idle("prio_idle");
    chk("prio_host_literal", last_word, 24'h01235A);
    chk("final_frames_seen", exp_frames.size(), 0);
    chk("final_rsp_seen", exp_rsp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
